// File: rtl/axil_sw_led_poller.sv
`default_nettype none
// ============================================================================
//  Module   : axil_sw_led_poller
//  Purpose  : AXI4-Lite master that periodically reads a switch register
//             from a slave and writes that value, optionally inverted, to
//             an LED register in the same slave. It keeps a shadow copy of
//             the last LED value the slave acknowledged, a count of
//             successful updates, and a sticky error flag.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    ACLK, ARESET        clock, asynchronous active-high reset
//    enable              permits new polls (an active transaction always
//                        runs to completion)
//    invert              write ~switches instead of switches (sampled on
//                        the read-data handshake)
//    m_axi_aw*/w*/b*     AXI4-Lite write address / data / response
//    m_axi_ar*/r*        AXI4-Lite read address / data
//    led_shadow          last LED value acknowledged with OKAY
//    upd_count           number of successful LED updates (wraps)
//    busy                a transaction is in progress
//    err                 sticky: a read or write returned a non-OKAY response
// ============================================================================
module axil_sw_led_poller #(
  parameter int unsigned POLL_CYCLES = 1000,
  parameter logic [31:0] SW_ADDR     = 32'h0,
  parameter logic [31:0] LED_ADDR    = 32'h4
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        enable,
  input  logic        invert,
  // write address channel
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  // write data channel
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  // write response channel
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  // read address channel
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  // read data channel
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  // status
  output logic [31:0] led_shadow,
  output logic [15:0] upd_count,
  output logic        busy,
  output logic        err
);

  // Timer counts POLL_CYCLES-1 down to 0, so it only needs to hold POLL_CYCLES-1.
  localparam int unsigned      c_TW         = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [c_TW-1:0]  c_TIMER_LOAD = c_TW'(POLL_CYCLES - 1);
  localparam logic [1:0]       c_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AWW  = 3'd3,
    S_B    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [c_TW-1:0]   r_timer,      w_timer_nxt;
  logic              r_arvalid,    w_arvalid_nxt;
  logic [31:0]       r_araddr,     w_araddr_nxt;
  logic              r_rready,     w_rready_nxt;
  logic              r_awvalid,    w_awvalid_nxt;
  logic [31:0]       r_awaddr,     w_awaddr_nxt;
  logic              r_wvalid,     w_wvalid_nxt;
  logic [31:0]       r_wdata,      w_wdata_nxt;
  logic              r_bready,     w_bready_nxt;
  logic [31:0]       r_led_shadow, w_led_shadow_nxt;
  logic [15:0]       r_upd_count,  w_upd_count_nxt;
  logic              r_err,        w_err_nxt;

  // Handshakes on the two write request channels, which complete independently.
  logic              w_aw_hs;
  logic              w_w_hs;

  assign w_aw_hs = r_awvalid & m_axi_awready;
  assign w_w_hs  = r_wvalid  & m_axi_wready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic. Every AXI output is registered, so the
  // values computed here are what the bus will see after the next edge.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_arvalid_nxt    = r_arvalid;
    w_araddr_nxt     = r_araddr;
    w_rready_nxt     = r_rready;
    w_awvalid_nxt    = r_awvalid;
    w_awaddr_nxt     = r_awaddr;
    w_wvalid_nxt     = r_wvalid;
    w_wdata_nxt      = r_wdata;
    w_bready_nxt     = r_bready;
    w_led_shadow_nxt = r_led_shadow;
    w_upd_count_nxt  = r_upd_count;
    w_err_nxt        = r_err;

    case (r_state)
      S_IDLE: begin
        // The timer only advances while polling is enabled; disabling
        // freezes it so re-enabling resumes the remaining count.
        if (enable) begin
          if (r_timer == '0) begin
            w_state_nxt   = S_AR;
            w_arvalid_nxt = 1'b1;
            w_araddr_nxt  = SW_ADDR;
          end else begin
            w_timer_nxt = r_timer - c_TW'(1);
          end
        end
      end

      S_AR: begin
        if (m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_R;
        end
      end

      S_R: begin
        if (m_axi_rvalid) begin
          w_rready_nxt = 1'b0;
          if (m_axi_rresp == c_RESP_OKAY) begin
            w_wdata_nxt   = invert ? ~m_axi_rdata : m_axi_rdata;
            w_awaddr_nxt  = LED_ADDR;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = S_AWW;
          end else begin
            // Failed read: nothing trustworthy to write, go back to waiting.
            w_err_nxt   = 1'b1;
            w_timer_nxt = c_TIMER_LOAD;
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_AWW: begin
        if (w_aw_hs) begin
          w_awvalid_nxt = 1'b0;
        end
        if (w_w_hs) begin
          w_wvalid_nxt = 1'b0;
        end
        // A channel is finished once its valid is already low or its
        // handshake happens this cycle; both may finish together.
        if ((!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs)) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_B;
        end
      end

      S_B: begin
        if (m_axi_bvalid) begin
          w_bready_nxt = 1'b0;
          w_timer_nxt  = c_TIMER_LOAD;
          w_state_nxt  = S_IDLE;
          if (m_axi_bresp == c_RESP_OKAY) begin
            w_led_shadow_nxt = r_wdata;
            w_upd_count_nxt  = r_upd_count + 16'd1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_timer_nxt   = c_TIMER_LOAD;
        w_arvalid_nxt = 1'b0;
        w_rready_nxt  = 1'b0;
        w_awvalid_nxt = 1'b0;
        w_wvalid_nxt  = 1'b0;
        w_bready_nxt  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath / output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_timer      <= c_TIMER_LOAD;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_awaddr     <= '0;
      r_wvalid     <= 1'b0;
      r_wdata      <= '0;
      r_bready     <= 1'b0;
      r_led_shadow <= '0;
      r_upd_count  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_timer      <= w_timer_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_araddr     <= w_araddr_nxt;
      r_rready     <= w_rready_nxt;
      r_awvalid    <= w_awvalid_nxt;
      r_awaddr     <= w_awaddr_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_wdata      <= w_wdata_nxt;
      r_bready     <= w_bready_nxt;
      r_led_shadow <= w_led_shadow_nxt;
      r_upd_count  <= w_upd_count_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

  assign led_shadow    = r_led_shadow;
  assign upd_count     = r_upd_count;
  assign busy          = (r_state != S_IDLE);
  assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axil_sw_led_poller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_sw_led_poller
//  Purpose  : Self-checking bench for axil_sw_led_poller. A behavioural
//             AXI4-Lite slave with configurable per-channel delays and
//             responses serves the poller; expected results come from a
//             transaction-level model of the poll/write/acknowledge rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axil_sw_led_poller;

  localparam int          P    = 8;
  localparam logic [31:0] SWA  = 32'h0;
  localparam logic [31:0] LEDA = 32'h4;

  logic        ACLK   = 1'b0;
  logic        ARESET;
  logic        enable;
  logic        invert = 1'b0;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready  = 1'b0;
  logic [1:0]  m_axi_bresp   = 2'b00;
  logic        m_axi_bvalid  = 1'b0;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata   = 32'h0;
  logic [1:0]  m_axi_rresp   = 2'b00;
  logic        m_axi_rvalid  = 1'b0;
  logic        m_axi_rready;
  logic [31:0] led_shadow;
  logic [15:0] upd_count;
  logic        busy;
  logic        err;

  always #5 ACLK = ~ACLK;

  axil_sw_led_poller #(
    .POLL_CYCLES (P),
    .SW_ADDR     (SWA),
    .LED_ADDR    (LEDA)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .enable        (enable),
    .invert        (invert),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .led_shadow    (led_shadow),
    .upd_count     (upd_count),
    .busy          (busy),
    .err           (err)
  );

  // ---------------------------------------------------------------- scoring
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------ slave configuration
  int          cfg_ar_dly = 0, cfg_r_dly = 0, cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0;
  logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;
  logic [31:0] sw_reg = 32'h0;
  bit          rand_inv = 1'b0, fixed_inv = 1'b0, gap_en = 1'b1;

  // ------------------------------------------------ slave / monitor state
  int          cyc = 0, n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0, n_done = 0;
  int          done_cyc = 0, rise_cyc = 0, aw_hi = 0, w_hi = 0;
  int          overlap_err = 0, stab_err = 0, gap_err = 0;
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  bit          done_valid = 0, r_pend = 0, aw_got = 0, w_got = 0, b_pend = 0, ar_prev = 0;
  bit          hold_ar = 0, hold_aw = 0, hold_w = 0;
  logic [31:0] cap_araddr = 0, cap_awaddr = 0, cap_wdata = 0;
  logic [31:0] hold_araddr = 0, hold_awaddr = 0, hold_wdata = 0;
  logic        cap_invert = 0;

  // Slave + protocol monitor. At the edge it sees pre-edge values (the DUT
  // updates afterwards), so handshakes are recorded first; 1 time unit later
  // it reacts to the DUT's new outputs and drives the next slave response.
  always @(posedge ACLK) begin
    cyc++;
    if (ARESET) begin
      r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
      hold_ar = 0; hold_aw = 0; hold_w = 0; done_valid = 0;
    end else begin
      if (hold_ar && (!m_axi_arvalid || m_axi_araddr != hold_araddr)) stab_err++;
      if (hold_aw && (!m_axi_awvalid || m_axi_awaddr != hold_awaddr)) stab_err++;
      if (hold_w  && (!m_axi_wvalid  || m_axi_wdata  != hold_wdata))  stab_err++;
      hold_ar = m_axi_arvalid && !m_axi_arready; hold_araddr = m_axi_araddr;
      hold_aw = m_axi_awvalid && !m_axi_awready; hold_awaddr = m_axi_awaddr;
      hold_w  = m_axi_wvalid  && !m_axi_wready;  hold_wdata  = m_axi_wdata;
      if ((m_axi_arvalid || m_axi_rready) && (m_axi_awvalid || m_axi_wvalid || m_axi_bready))
        overlap_err++;
      if (m_axi_awvalid) aw_hi++;
      if (m_axi_wvalid)  w_hi++;

      if (m_axi_arvalid && m_axi_arready) begin
        n_ar++; cap_araddr = m_axi_araddr; r_pend = 1; r_cnt = 0;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        n_r++; r_pend = 0; cap_invert = invert;
        if (m_axi_rresp != 2'b00) begin
          n_done++; done_cyc = cyc; done_valid = 1;
        end
      end
      if (m_axi_awvalid && m_axi_awready) begin
        n_aw++; cap_awaddr = m_axi_awaddr; aw_got = 1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        n_w++; cap_wdata = m_axi_wdata; w_got = 1;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        n_b++; b_pend = 0; n_done++; done_cyc = cyc; done_valid = 1;
      end
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
      end
    end

    #1;
    if (ARESET) begin
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; ar_prev = 0;
    end else begin
      // A new poll starts here; in steady state it must follow the previous
      // transaction's end by exactly P cycles.
      if (m_axi_arvalid && !ar_prev) begin
        rise_cyc = cyc;
        if (gap_en && done_valid && (cyc - done_cyc != P)) gap_err++;
      end
      ar_prev = m_axi_arvalid;

      if (m_axi_arvalid) begin m_axi_arready = (ar_cnt >= cfg_ar_dly); ar_cnt++; end
      else begin m_axi_arready = 0; ar_cnt = 0; end
      if (m_axi_awvalid) begin m_axi_awready = (aw_cnt >= cfg_aw_dly); aw_cnt++; end
      else begin m_axi_awready = 0; aw_cnt = 0; end
      if (m_axi_wvalid) begin m_axi_wready = (w_cnt >= cfg_w_dly); w_cnt++; end
      else begin m_axi_wready = 0; w_cnt = 0; end

      if (r_pend) begin
        m_axi_rvalid = (r_cnt >= cfg_r_dly); r_cnt++;
        m_axi_rdata  = (cap_araddr == SWA) ? sw_reg : 32'hDEAD_BEEF;
        m_axi_rresp  = cfg_rresp;
      end else begin
        m_axi_rvalid = 0; m_axi_rdata = $urandom; m_axi_rresp = 2'b00;
      end
      if (b_pend) begin
        m_axi_bvalid = (b_cnt >= cfg_b_dly); b_cnt++; m_axi_bresp = cfg_bresp;
      end else begin
        m_axi_bvalid = 0; m_axi_bresp = 2'b00;
      end
    end
    invert = rand_inv ? 1'($urandom_range(0, 1)) : fixed_inv;
  end

  // ------------------------------------------------------- reference model
  logic [31:0] exp_led = 32'h0;
  logic [15:0] exp_cnt = 16'h0;
  logic        exp_err = 1'b0;

  task automatic wait_done(input int target);
    int k = 0;
    while (n_done < target && k < 400) begin
      @(posedge ACLK); #1; k++;
    end
    #1;
    check_eq("txn_done", n_done, target);
  endtask

  // One poll: the switches are read from SW_ADDR; on an OKAY read the value
  // (inverted if invert was high at the read-data handshake) goes to LED_ADDR;
  // only an OKAY write response updates the shadow and count; any non-OKAY
  // response sets the sticky error.
  task automatic run_txn(input logic [31:0] sw, input logic [1:0] rr, input logic [1:0] br);
    int d0, aw0, w0, b0;
    logic [31:0] exp_w;
    sw_reg = sw; cfg_rresp = rr; cfg_bresp = br;
    d0 = n_done; aw0 = n_aw; w0 = n_w; b0 = n_b;
    wait_done(d0 + 1);
    check_eq("araddr", cap_araddr, SWA);
    if (rr != 2'b00) begin
      exp_err = 1'b1;
      check_eq("aw_after_rerr", n_aw - aw0, 0);
      check_eq("w_after_rerr", n_w - w0, 0);
    end else begin
      exp_w = cap_invert ? ~sw : sw;
      check_eq("wdata", cap_wdata, exp_w);
      check_eq("awaddr", cap_awaddr, LEDA);
      check_eq("b_count", n_b - b0, 1);
      if (br == 2'b00) begin
        exp_led = exp_w;
        exp_cnt = exp_cnt + 16'd1;
      end else begin
        exp_err = 1'b1;
      end
    end
    check_eq("led_shadow", led_shadow, exp_led);
    check_eq("upd_count", upd_count, exp_cnt);
    check_eq("err", err, exp_err);
    check_eq("busy_idle", busy, 0);
  endtask

  task automatic drop_enable_in_r();
    int k = 0;
    while (!m_axi_rready && k < 100) begin
      @(posedge ACLK); #1; k++;
    end
    check_eq("reached_r", m_axi_rready, 1);
    enable = 1'b0;
  endtask

  // ------------------------------------------------------------ main flow
  initial begin
    int rel_cyc, en_cyc, n0, a0, w0, k;
    ARESET = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge ACLK);
    #2;
    check_eq("rst_valids", {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
    check_eq("rst_araddr", m_axi_araddr, 0);
    check_eq("rst_awaddr", m_axi_awaddr, 0);
    check_eq("rst_wdata", m_axi_wdata, 0);
    check_eq("rst_status", {led_shadow, upd_count, busy, err}, 0);
    check_eq("prot_strb", {m_axi_awprot, m_axi_arprot, m_axi_wstrb}, 32'hF);

    // Basic poll, zero-wait slave
    @(posedge ACLK); #1;
    ARESET = 1'b0; enable = 1'b1; rel_cyc = cyc;
    run_txn(32'h0000_00A5, 2'b00, 2'b00);
    check_eq("first_poll_delay", rise_cyc - rel_cyc, P);
    check_eq("zero_wait_latency", done_cyc - rise_cyc, 4);
    check_eq("led_A5", led_shadow, 32'h0000_00A5);

    // Inverted write
    fixed_inv = 1'b1;
    run_txn(32'h0000_00A5, 2'b00, 2'b00);
    check_eq("wdata_inv", cap_wdata, 32'hFFFF_FF5A);
    check_eq("led_inv", led_shadow, 32'hFFFF_FF5A);
    fixed_inv = 1'b0;

    // Slow AW, fast W: each valid drops independently
    cfg_aw_dly = 3; a0 = aw_hi; w0 = w_hi;
    run_txn(32'h1357_9BDF, 2'b00, 2'b00);
    check_eq("awvalid_cycles", aw_hi - a0, 4);
    check_eq("wvalid_cycles", w_hi - w0, 1);
    cfg_aw_dly = 0;

    // Error responses: read error, then write error
    run_txn(32'h0000_00FF, 2'b10, 2'b00);
    run_txn(32'h0000_0F0F, 2'b00, 2'b10);

    // Enable dropped mid-transaction: finish it, then stay idle
    gap_en = 1'b0; cfg_r_dly = 5;
    fork
      run_txn(32'h1234_5678, 2'b00, 2'b00);
      drop_enable_in_r();
    join
    cfg_r_dly = 0; n0 = n_ar;
    repeat (100) @(posedge ACLK);
    #1;
    check_eq("no_poll_disabled", n_ar - n0, 0);
    check_eq("idle_disabled", busy, 0);
    enable = 1'b1; en_cyc = cyc;
    run_txn(32'hCAFE_F00D, 2'b00, 2'b00);
    check_eq("poll_after_enable", rise_cyc - en_cyc, P);
    gap_en = 1'b1;

    // Asynchronous reset while in the write phase
    cfg_aw_dly = 10; cfg_w_dly = 10; sw_reg = 32'h0BAD_F00D; cfg_rresp = 2'b00; cfg_bresp = 2'b00;
    k = 0;
    while (!m_axi_awvalid && k < 100) begin
      @(posedge ACLK); #1; k++;
    end
    check_eq("reached_aww", m_axi_awvalid, 1);
    #2;
    ARESET = 1'b1;
    #1;
    check_eq("rst_aww_valids", {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
    check_eq("rst_aww_wdata", m_axi_wdata, 0);
    check_eq("rst_aww_awaddr", m_axi_awaddr, 0);
    check_eq("rst_aww_status", {led_shadow, upd_count, busy, err}, 0);
    exp_led = 32'h0; exp_cnt = 16'h0; exp_err = 1'b0;
    cfg_aw_dly = 0; cfg_w_dly = 0;
    @(posedge ACLK); #1;
    ARESET = 1'b0; rel_cyc = cyc;
    run_txn(32'h0000_3C3C, 2'b00, 2'b00);
    check_eq("poll_after_reset", rise_cyc - rel_cyc, P);

    // Counter wrap: preload near the top rather than run 65536 polls
    force dut.r_upd_count = 16'hFFFE;
    @(posedge ACLK); #1;
    release dut.r_upd_count;
    exp_cnt = 16'hFFFE;
    check_eq("cnt_preload", upd_count, 16'hFFFE);
    run_txn(32'h0000_0001, 2'b00, 2'b00);
    run_txn(32'h0000_0002, 2'b00, 2'b00);
    check_eq("cnt_wrap", upd_count, 0);

    // Randomized polls: random data, delays, invert toggling every cycle,
    // occasional error responses
    rand_inv = 1'b1;
    for (int t = 0; t < 30; t++) begin
      cfg_ar_dly = $urandom_range(0, 3);
      cfg_r_dly  = $urandom_range(0, 3);
      cfg_aw_dly = $urandom_range(0, 3);
      cfg_w_dly  = $urandom_range(0, 3);
      cfg_b_dly  = $urandom_range(0, 3);
      run_txn($urandom,
              ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00,
              ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00);
    end

    check_eq("channel_overlap", overlap_err, 0);
    check_eq("valid_stability", stab_err, 0);
    check_eq("poll_period", gap_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
`default_nettype wire

// File: doc/axil_sw_led_poller.md
AXIL_SW_LED_POLLER -- requirements
Module: axil_sw_led_poller

Interface
REQ-001 SHALL have parameter POLL_CYCLES, default 1000: ACLK cycles from re-entering IDLE to the next poll; legal range >=1.
REQ-002 SHALL have parameter SW_ADDR, default 32'h0: address of the switch input register in the slave.
REQ-003 SHALL have parameter LED_ADDR, default 32'h4: address of the LED output register in the slave.
REQ-004 SHALL have ports ACLK in 1, the single clock, and ARESET in 1, an asynchronous active-high reset.
REQ-005 SHALL have port enable in 1: permits new polls.
REQ-006 SHALL have port invert in 1: when 1, write the bitwise inverse of the switch value to the LEDs.
REQ-007 SHALL have AXI4-Lite master write ports: m_axi_awaddr out 32, m_axi_awprot out 3 (always 0), m_axi_awvalid out 1, m_axi_awready in 1, m_axi_wdata out 32, m_axi_wstrb out 4 (always 4'hF), m_axi_wvalid out 1, m_axi_wready in 1, m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1.
REQ-008 SHALL have AXI4-Lite master read ports: m_axi_araddr out 32, m_axi_arprot out 3 (always 0), m_axi_arvalid out 1, m_axi_arready in 1, m_axi_rdata in 32, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1.
REQ-009 SHALL have status outputs: led_shadow out 32 (last LED value acknowledged OKAY), upd_count out 16 (count of successful LED updates), busy out 1 (state is not IDLE), err out 1 (sticky error flag).

Function
REQ-010 SHALL implement the states IDLE, AR, R, AWW and B.
REQ-011 IDLE SHALL load the timer with POLL_CYCLES-1 on entry and decrement it by 1 per cycle while enable=1; it SHALL hold the timer while enable=0.
REQ-012 The timer reaching 0 with enable=1 SHALL move IDLE->AR on the next edge.
REQ-013 AR SHALL hold arvalid=1 and araddr=SW_ADDR until arready=1, then move to R; araddr SHALL be stable while arvalid=1.
REQ-014 R SHALL hold rready=1; on rvalid=1 with rresp=2'b00 it SHALL latch wdata = invert ? ~rdata : rdata and move to AWW.
REQ-015 On rvalid=1 with rresp!=0, R SHALL set err and return to IDLE without any write.
REQ-016 AWW SHALL assert awvalid (awaddr=LED_ADDR) and wvalid together; each SHALL drop independently in the cycle after its own ready is sampled high; when both handshakes are complete (including in the same cycle) the block SHALL move to B.
REQ-017 B SHALL hold bready=1; on bvalid=1 it SHALL return to IDLE; if bresp=0 it SHALL load led_shadow with wdata and increment upd_count, wrapping 16'hFFFF->0; otherwise it SHALL set err.
REQ-018 invert SHALL be sampled only in the R handshake cycle.
REQ-019 Only one transaction SHALL be outstanding; the read and write channels SHALL never be active at the same time.
REQ-020 Deasserting enable outside IDLE SHALL NOT abort the transaction; the block SHALL complete the sequence and then wait in IDLE.
REQ-021 Valid outputs SHALL come from registers; once asserted, a valid SHALL NOT drop before its handshake completes (AXI rule).
REQ-022 err SHALL be cleared only by reset.
REQ-023 Minimum poll period SHALL be POLL_CYCLES + the AXI handshake cycles, with zero-wait slave latency AR->R->AWW->B = 4 cycles.

Reset
REQ-024 ARESET=1 SHALL, asynchronously: set state=IDLE, all valid/ready outputs 0, awaddr/araddr/wdata 0, led_shadow 0, upd_count 0, err 0, busy 0, timer=POLL_CYCLES-1.
REQ-025 Reset during any state SHALL drop all valids immediately; after release, the first poll SHALL occur POLL_CYCLES enabled cycles later.

Verification
REQ-026 POLL_CYCLES=8, zero-wait slave, reg0=32'h0000_00A5, invert=0, enable=1 -> read at 0x0, write 32'h0000_00A5 to 0x4, led_shadow=32'hA5, upd_count=1, err=0.
REQ-027 Same as REQ-026 with invert=1 -> wdata=32'hFFFF_FF5A, led_shadow=32'hFFFF_FF5A.
REQ-028 awready delayed 3 cycles, wready 0 cycles -> wvalid drops after 1 cycle, awvalid held 4 cycles, exactly one B accepted.
REQ-029 rresp=2'b10 -> err=1, no AW/W activity, upd_count unchanged; bresp=2'b10 -> err=1, led_shadow unchanged.
REQ-030 enable dropped in state R -> write completes, then no further polls over 100 cycles; enable restored -> next poll 8 cycles later.
REQ-031 ARESET pulsed while in AWW -> all valids 0 in the same cycle, outputs at reset values; 65536 successful updates -> upd_count wraps to 0.
